// File: rtl/JZJCoreFTypes.sv
// rtl/JZJCoreFTypes.sv - shared types, funct3 encodings and access checking for the load/store unit
package JZJCoreFTypes;

  // Single write strobe towards the RAM wrapper
  typedef logic WriteEnable_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_PRELOAD,
    STORE_WRITE,
    RESPOND
  } MemState_t;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // True when the access must be rejected: bad funct3, misaligned, or beyond the RAM
  function automatic logic access_error(input logic is_store, input logic [2:0] f3,
                                        input logic [31:0] address, input int ram_a_width);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (is_store)
      illegal = !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
    else
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misaligned = (((f3 == F3_LH) || (f3 == F3_LHU)) && address[0]) ||
                 ((f3 == F3_LW) && (address[1:0] != 2'b00));
    out_of_range = (address >> (ram_a_width + 2)) != 32'd0;
    return illegal || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequences core load/store requests onto the RAM wrapper
module load_store_unit
  import JZJCoreFTypes::*;
#(
  parameter int RAM_A_WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reqValid,
  output logic         reqReady,
  input  logic         reqIsStore,
  input  logic [2:0]   reqFunct3,
  input  logic [31:0]  reqAddress,
  input  logic [31:0]  reqData,
  output logic         rspValid,
  input  logic         rspReady,
  output logic [31:0]  rspData,
  output logic         rspError,
  output logic [2:0]   funct3,
  output logic [17:0]  backendAddress,
  output logic [1:0]   offset,
  output WriteEnable_t ramWriteEnable,
  output logic [31:0]  rs2,
  input  logic [31:0]  ramDataOut
);

  MemState_t   state;
  MemState_t   next_state;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] address_q;
  logic [31:0] data_q;
  logic        req_error;
  logic        held_error;

  // Error of the incoming request decides the first transition; the held one drives the response
  assign req_error  = access_error(reqIsStore, reqFunct3, reqAddress, RAM_A_WIDTH);
  assign held_error = access_error(is_store_q, funct3_q, address_q, RAM_A_WIDTH);

  // RAM-side outputs come only from the captured request so they stay stable while busy
  assign funct3         = funct3_q;
  assign backendAddress = 18'(address_q[RAM_A_WIDTH+1:2]);
  assign offset         = address_q[1:0];
  assign rs2            = data_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Capture the request on accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      address_q  <= 32'd0;
      data_q     <= 32'd0;
    end else if (reqValid && (state == IDLE)) begin
      is_store_q <= reqIsStore;
      funct3_q   <= reqFunct3;
      address_q  <= reqAddress;
      data_q     <= reqData;
    end
  end

  // Next state and handshake/strobe outputs
  always_comb begin
    next_state     = state;
    reqReady       = 1'b0;
    rspValid       = 1'b0;
    rspError       = 1'b0;
    rspData        = 32'd0;
    ramWriteEnable = 1'b0;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          if (req_error)             next_state = RESPOND;
          else if (!reqIsStore)      next_state = LOAD;
          else if (reqFunct3 == F3_SW) next_state = STORE_WRITE;
          else                       next_state = STORE_PRELOAD;
        end
      end
      LOAD:          next_state = RESPOND;
      // Sub-word stores let the wrapper latch the old word before merging
      STORE_PRELOAD: next_state = STORE_WRITE;
      STORE_WRITE: begin
        ramWriteEnable = 1'b1;
        next_state     = RESPOND;
      end
      RESPOND: begin
        rspValid = 1'b1;
        rspError = held_error;
        // Read data stays valid here because the address has not moved since LOAD
        if (!held_error && !is_store_q) rspData = ramDataOut;
        if (rspReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural RAM wrapper
module tb_load_store_unit;
  import JZJCoreFTypes::*;

  localparam int RAM_A_WIDTH = 16;
  localparam int WORDS = 1 << RAM_A_WIDTH;

  logic         clock;
  logic         reset;
  logic         reqValid;
  logic         reqReady;
  logic         reqIsStore;
  logic [2:0]   reqFunct3;
  logic [31:0]  reqAddress;
  logic [31:0]  reqData;
  logic         rspValid;
  logic         rspReady;
  logic [31:0]  rspData;
  logic         rspError;
  logic [2:0]   funct3;
  logic [17:0]  backendAddress;
  logic [1:0]   offset;
  WriteEnable_t ramWriteEnable;
  logic [31:0]  rs2;
  logic [31:0]  ramDataOut;

  load_store_unit #(.RAM_A_WIDTH(RAM_A_WIDTH)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqIsStore(reqIsStore),
    .reqFunct3(reqFunct3), .reqAddress(reqAddress), .reqData(reqData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspError(rspError),
    .funct3(funct3), .backendAddress(backendAddress), .offset(offset),
    .ramWriteEnable(ramWriteEnable), .rs2(rs2), .ramDataOut(ramDataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          we;
  } exp_t;

  logic [31:0] mem [0:WORDS-1];
  logic [31:0] ref_mem [0:WORDS-1];
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          we_total = 0;
  logic [31:0] last_data;

  // Big-endian sub-word extraction as the RAM wrapper presents it
  function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] b);
    logic [7:0]  by;
    logic [15:0] hw;
    by = w[8*(3-int'(b)) +: 8];
    hw = b[1] ? w[15:0] : w[31:16];
    case (f3)
      3'd0:    return {{24{by[7]}}, by};
      3'd1:    return {{16{hw[15]}}, hw};
      3'd2:    return w;
      3'd4:    return {24'd0, by};
      3'd5:    return {16'd0, hw};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d,
                                           input logic [2:0] f3, input logic [1:0] b);
    logic [31:0] r;
    r = w;
    case (f3)
      3'd0: r[8*(3-int'(b)) +: 8] = d[7:0];
      3'd1: if (b[1]) r[15:0] = d[15:0]; else r[31:16] = d[15:0];
      3'd2: r = d;
      default: r = w;
    endcase
    return r;
  endfunction

  // RAM wrapper model: registered formatted read, merged write on strobe
  always @(posedge clock) begin
    if (ramWriteEnable)
      mem[backendAddress[RAM_A_WIDTH-1:0]] <= st_merge(mem[backendAddress[RAM_A_WIDTH-1:0]], rs2, funct3, offset);
    ramDataOut <= ld_fmt(mem[backendAddress[RAM_A_WIDTH-1:0]], funct3, offset);
  end

  always @(negedge clock) begin
    if (ramWriteEnable) we_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one access; updates the shadow memory for stores
  function automatic exp_t predict(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit legal;
    bit aligned;
    bit inrange;
    logic [RAM_A_WIDTH-1:0] idx;
    legal   = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    aligned = 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) aligned = (a % 2 == 0);
    if (f3 == 3'd2)               aligned = (a % 4 == 0);
    inrange = a < (32'd1 << (RAM_A_WIDTH + 2));
    e.err  = !(legal && aligned && inrange);
    e.we   = (!e.err && st) ? 1 : 0;
    e.lat  = e.err ? 1 : ((st && f3 != 3'd2) ? 3 : 2);
    e.data = 32'd0;
    idx    = a[RAM_A_WIDTH+1:2];
    if (!e.err) begin
      if (st) ref_mem[idx] = st_merge(ref_mem[idx], d, f3, a[1:0]);
      else    e.data = ld_fmt(ref_mem[idx], f3, a[1:0]);
    end
    return e;
  endfunction

  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int stall);
    exp_t        e;
    int          lat;
    int          we0;
    logic [31:0] held;
    @(negedge clock);
    check("req_ready_idle", 32'(reqReady), 32'd1);
    reqValid   = 1'b1;
    reqIsStore = st;
    reqFunct3  = f3;
    reqAddress = a;
    reqData    = d;
    sb_q.push_back(predict(st, f3, a, d));
    we0 = we_total;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      reqValid   = 1'b0;
      reqAddress = $urandom;
      reqData    = $urandom;
      lat++;
    end while (!rspValid && lat < 20);
    e = sb_q.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("req_ready_busy", 32'(reqReady), 32'd0);
    check("backend_addr", 32'(backendAddress), 32'(a[RAM_A_WIDTH+1:2]));
    held = rspData;
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(rspValid), 32'd1);
      check("hold_data", rspData, held);
      check("hold_ready", 32'(reqReady), 32'd0);
    end
    check("rsp_data", rspData, e.data);
    check("rsp_error", 32'(rspError), 32'(e.err));
    last_data = rspData;
    rspReady = 1'b1;
    @(negedge clock);
    rspReady = 1'b0;
    check("done_valid", 32'(rspValid), 32'd0);
    check("done_ready", 32'(reqReady), 32'd1);
    check("we_cycles", 32'(we_total - we0), 32'(e.we));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(reqReady), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rspValid), 32'd0);
    check({tag, "_rsp_error"}, 32'(rspError), 32'd0);
    check({tag, "_rsp_data"}, rspData, 32'd0);
    check({tag, "_we"}, 32'(ramWriteEnable), 32'd0);
    check({tag, "_regs"}, {funct3, offset, 27'd0}, 32'd0);
    check({tag, "_baddr"}, 32'(backendAddress), 32'd0);
    check({tag, "_rs2"}, rs2, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    logic [2:0] f3;
    logic [31:0] a;
    reset = 1'b0;
    reqValid = 1'b0; reqIsStore = 1'b0; reqFunct3 = 3'd0;
    reqAddress = 32'd0; reqData = 32'd0; rspReady = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;

    // lw after sw
    access(1'b1, F3_SW, 32'h10, 32'h11223344, 0);
    access(1'b0, F3_LW, 32'h10, 32'd0, 0);
    check("lw_const", last_data, 32'h11223344);

    // sb merge into existing word
    access(1'b1, F3_SB, 32'h13, 32'h000000AA, 0);
    access(1'b0, F3_LW, 32'h10, 32'd0, 0);
    check("sb_const", last_data, 32'h112233AA);

    // misaligned halfword load
    access(1'b0, F3_LH, 32'h11, 32'd0, 0);

    // sign/zero extension of a byte
    access(1'b1, F3_SW, 32'h10, 32'h0000FF00, 0);
    access(1'b0, F3_LB, 32'h12, 32'd0, 0);
    check("lb_const", last_data, 32'hFFFFFFFF);
    access(1'b0, F3_LBU, 32'h12, 32'd0, 0);
    check("lbu_const", last_data, 32'h000000FF);

    // response back-pressure
    access(1'b1, F3_SW, 32'h0, 32'hDEADBEEF, 5);
    access(1'b0, F3_LW, 32'h0, 32'd0, 3);
    check("sw_const", last_data, 32'hDEADBEEF);

    // range and funct3 boundaries
    access(1'b1, F3_SW, 32'h0003FFFC, 32'h5A5A1234, 0);
    access(1'b0, F3_LHU, 32'h0003FFFE, 32'd0, 0);
    check("top_lhu_const", last_data, 32'h00001234);
    access(1'b0, F3_LW, 32'h00040000, 32'd0, 0);
    access(1'b1, F3_SW, 32'h80000000, 32'h1, 0);
    access(1'b1, 3'b011, 32'h4, 32'h1, 0);
    access(1'b0, 3'b110, 32'h4, 32'd0, 0);
    access(1'b1, F3_SH, 32'h13, 32'h1, 0);
    access(1'b1, F3_SW, 32'h16, 32'h1, 0);

    // reset during STORE_PRELOAD of sh
    access(1'b1, F3_SW, 32'h20, 32'hCAFEBABE, 0);
    @(negedge clock);
    reqValid = 1'b1; reqIsStore = 1'b1; reqFunct3 = F3_SH;
    reqAddress = 32'h22; reqData = 32'h00001234;
    we0 = we_total;
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    check("preload_we", 32'(ramWriteEnable), 32'd0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("midreset_we_cycles", 32'(we_total - we0), 32'd0);
    access(1'b0, F3_LW, 32'h20, 32'd0, 0);
    check("midreset_word", last_data, 32'hCAFEBABE);

    // random traffic over a small window of initialised words
    for (int i = 0; i < 16; i++) access(1'b1, F3_SW, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | 32'h00100000;
      access(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 2));
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: RAM_A_WIDTH, 16, log2 of RAM word count; legal range 1..18.
REQ-002 SHALL have ports, one per line:
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- reqValid  in  1  core presents an access.
- reqReady  out  1  unit can accept an access.
- reqIsStore  in  1  1 = store, 0 = load.
- reqFunct3  in  3  RV32I load/store funct3.
- reqAddress  in  32  byte address.
- reqData  in  32  store data, big endian.
- rspValid  out  1  response available.
- rspReady  in  1  core consumes the response.
- rspData  out  32  load result, big endian, extended per funct3; 0 for stores.
- rspError  out  1  misaligned or out-of-range access; no RAM effect.
- funct3  out  3  to RAM wrapper.
- backendAddress  out  18  word address to RAM wrapper.
- offset  out  2  byte offset to RAM wrapper.
- ramWriteEnable  out  WriteEnable_t  write strobe to RAM wrapper.
- rs2  out  32  store data to RAM wrapper.
- ramDataOut  in  32  formatted RAM read data, valid one posedge after the address is presented.

Function
REQ-003 SHALL implement states IDLE, LOAD, STORE_PRELOAD, STORE_WRITE, RESPOND.
REQ-004 SHALL assert reqReady only in IDLE; an access is accepted on a posedge with reqValid && reqReady.
REQ-005 SHALL capture reqIsStore, reqFunct3, reqAddress and reqData into registers on accept; funct3, backendAddress = address[RAM_A_WIDTH+1:2] zero-padded to 18 bits, offset = address[1:0] and rs2 SHALL be driven from these registers only, so they are stable in all non-IDLE states.
REQ-006 SHALL flag an error when any of these holds: halfword (funct3 001/101) with offset[0]=1; word (010) with offset!=0; address bits [31:RAM_A_WIDTH+2] nonzero; illegal funct3 (load 011/110/111; store other than 000/001/010).
REQ-007 On accept of an erroring access, SHALL go IDLE->RESPOND with rspError=1 and rspData=0, and SHALL never assert ramWriteEnable.
REQ-008 Load: IDLE->LOAD->RESPOND. In RESPOND, rspData SHALL equal ramDataOut, which is held valid because the address stays stable. Latency is 2 cycles from accept to rspValid.
REQ-009 Store sb/sh: IDLE->STORE_PRELOAD (we=0, RAM latches the old word)->STORE_WRITE (we=1 for exactly one cycle)->RESPOND. Latency is 3 cycles.
REQ-010 Store sw: IDLE->STORE_WRITE->RESPOND, with no preload. Latency is 2 cycles.
REQ-011 ramWriteEnable SHALL be 1 only in STORE_WRITE.
REQ-012 In RESPOND, SHALL hold rspValid=1 and rspData/rspError stable until rspReady; on rspValid && rspReady SHALL return to IDLE.
REQ-013 A new request SHALL NOT be accepted in the same cycle a response completes; there is no back-to-back overlap.
REQ-014 rspValid SHALL be 0 in every state except RESPOND.

Reset
REQ-015 On reset low, SHALL enter IDLE asynchronously and drive: reqReady=1, rspValid=0, rspError=0, rspData=0, ramWriteEnable=0, all captured registers=0.
REQ-016 Reset asserted mid-store SHALL deassert ramWriteEnable immediately. A store interrupted before STORE_WRITE SHALL leave RAM unmodified.

Structure
REQ-017 The state enum MemState_t and the funct3 encodings SHALL live in package JZJCoreFTypes, alongside WriteEnable_t.
REQ-018 Misalignment/range checking SHALL be a pure function in the same file; no sub-module is needed. The unit SHALL pair directly with RAMWrapper in the core top level.

Verification
REQ-019 lw at 0x00000010, RAM word 0x11223344: rspValid at cycle 2 after accept, rspData=0x11223344, rspError=0, no write strobe.
REQ-020 sb 0xAA at 0x00000013, word previously 0x11223344: one-cycle preload, then exactly one write-strobe cycle; a later lw from 0x10 returns 0x112233AA. Response latency is 3 cycles.
REQ-021 lh at 0x00000011: rspError=1 in RESPOND at cycle 1, ramWriteEnable never asserted, rspData=0.
REQ-022 lb at 0x00000012 with word 0x0000FF00 returns 0xFFFFFFFF; lbu at the same address returns 0x000000FF.
REQ-023 sw 0xDEADBEEF at 0x0 with rspReady held 0 for 5 cycles: rspValid stays 1 with data stable and reqReady stays 0; completion occurs the cycle rspReady rises.
REQ-024 Reset pulsed during STORE_PRELOAD of sh: ramWriteEnable never asserted, the target word is unchanged, and outputs match REQ-015 values immediately.
